dmem_store_buffer: RTL
======================

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of store entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 3, meaning width of sb_count (log2(DEPTH)+1).
REQ-003 SHALL have one clock and an asynchronous active-low reset, named clock and reset as in the core.
REQ-004 SHALL have port: clock  input  1  rising-edge clock.
REQ-005 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: memwriteM  input  1  core M-stage store strobe.
REQ-007 SHALL have port: ALUresultM  input  32  core M-stage byte address, for load or store.
REQ-008 SHALL have port: writedataM  input  32  core M-stage store data.
REQ-009 SHALL have port: readDataM  output  32  load data returned to core, combinational.
REQ-010 SHALL have port: mem_req  output  1  drain request to backing memory.
REQ-011 SHALL have port: mem_addr  output  32  drain address (head entry).
REQ-012 SHALL have port: mem_wdata  output  32  drain data (head entry).
REQ-013 SHALL have port: mem_ack  input  1  backing memory accepted the drain write.
REQ-014 SHALL have port: mem_raddr  output  32  backing memory read address, equal to ALUresultM.
REQ-015 SHALL have port: mem_rdata  input  32  backing memory combinational read data.
REQ-016 SHALL have port: sb_count  output  CNT_W  number of valid entries.
REQ-017 SHALL have port: sb_empty  output  1  sb_count==0.
REQ-018 SHALL have port: sb_full  output  1  sb_count==DEPTH.
REQ-019 SHALL have port: sb_overflow  output  1  sticky flag, set when a store is dropped.

Function
REQ-020 SHALL treat all stores as full 32-bit words; address match SHALL use bits [31:2] only.
REQ-021 SHALL push {ALUresultM, writedataM} at the tail on a rising edge with memwriteM=1 and space available; zero-cycle input latency, with the entry visible next cycle.
REQ-022 SHALL run a 2-state drain FSM: IDLE (mem_req=0) -> DRAIN when sb_count>0 or a push is occurring; DRAIN -> IDLE on the pop edge that leaves the buffer empty with no simultaneous push.
REQ-023 SHALL, in DRAIN, hold mem_req=1 and mem_addr/mem_wdata equal to the head entry, stable until an edge with mem_ack=1.
REQ-024 SHALL pop the head on a rising edge with mem_req=1 and mem_ack=1; mem_ack while mem_req=0 SHALL be ignored.
REQ-025 SHALL, on push and pop in the same cycle, perform both, leaving sb_count unchanged; this SHALL hold even when full.
REQ-026 SHALL, on push when full without a simultaneous pop, drop the store, leave the FIFO unchanged, and set sb_overflow=1 until reset.
REQ-027 SHALL wrap head/tail pointers modulo DEPTH.
REQ-028 SHALL drive mem_raddr=ALUresultM combinationally at all times.
REQ-029 SHALL, with forwarding compiled in, drive readDataM with the data of the youngest valid entry whose word address matches ALUresultM, else mem_rdata.
REQ-030 SHALL count the head entry being popped this cycle as valid for forwarding.

Reset
REQ-031 SHALL, while reset=0, asynchronously clear pointers, sb_count=0, sb_empty=1, sb_full=0, sb_overflow=0, FSM=IDLE, mem_req=0, mem_addr=0, mem_wdata=0.
REQ-032 SHALL, on reset mid-drain, discard all pending entries; mem_req SHALL fall without waiting for mem_ack.
REQ-033 SHALL have readDataM=mem_rdata during reset.

Configuration
REQ-034 SHALL provide macro DMEM_STORE_BUFFER_FORWARD_EN; when defined, readDataM forwards per REQ-029/030.
REQ-035 SHALL, when DMEM_STORE_BUFFER_FORWARD_EN is undefined, drive readDataM=mem_rdata unconditionally, with no compare logic synthesized.

Verification
REQ-036 SHALL cover: store 0xDEADBEEF to 0x100, mem_ack held 0 -> mem_req=1, mem_addr=0x100, mem_wdata=0xDEADBEEF stable for 5 cycles, sb_count=1.
REQ-037 SHALL cover: stores 0x11 then 0x22 to 0x200, then load 0x202 with mem_rdata=0 -> readDataM=0x22 (forward on); readDataM=0x0 (macro off).
REQ-038 SHALL cover: 4 stores with ack=0, a 5th store -> sb_full=1, sb_overflow=1, sb_count=4, and 4 drains in original order.
REQ-039 SHALL cover: full buffer, store with mem_ack=1 in the same cycle -> sb_count stays 4, sb_overflow=0, new entry drained last.
REQ-040 SHALL cover: 3 entries pending, reset pulsed low mid-cycle -> mem_req=0 immediately, sb_count=0; after release, no stale drains occur.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: write-through store buffer between the core M stage and data memory.
//
// Stores (always full 32-bit words) are queued in a DEPTH-entry circular FIFO and drained one
// at a time to the backing memory through a req/ack handshake. Loads read the backing memory
// combinationally. With forwarding built in, a load whose word address hits a pending store
// returns the youngest matching store's data instead.
//
// Build option: define DMEM_STORE_BUFFER_FORWARD_EN to enable store-to-load forwarding.
// Without it, readDataM is a straight wire from mem_rdata and no comparators exist.
//
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   memwriteM                 store strobe from the core M stage
//   ALUresultM, writedataM    byte address (load or store) and store data
//   readDataM                 load data returned to the core (combinational)
//   mem_req/addr/wdata/ack    drain handshake to the backing memory (head entry)
//   mem_raddr, mem_rdata      backing memory combinational read port
//   sb_count/empty/full       occupancy status
//   sb_overflow               sticky: a store was dropped because the buffer was full
module dmem_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             memwriteM,
  input  logic [31:0]      ALUresultM,
  input  logic [31:0]      writedataM,
  output logic [31:0]      readDataM,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  output logic [31:0]      mem_raddr,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] sb_count,
  output logic             sb_empty,
  output logic             sb_full,
  output logic             sb_overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {StIdle, StDrain} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q;
  logic [31:0]      addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic             full;
  logic             push;
  logic             pop;

  assign full = (count_q == CNT_W'(DEPTH));
  assign pop  = mem_req & mem_ack;
  // A simultaneous pop frees the head slot, so a store is accepted even when full.
  assign push = memwriteM & (~full | pop);

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if ((count_q != '0) || push) state_d = StDrain;
      end
      StDrain: begin
        if (pop && !push && (count_q == CNT_W'(1))) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: the drain port shows the head entry only while draining, zero otherwise.
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == StDrain) begin
      mem_req   = 1'b1;
      mem_addr  = addr_mem[head_q];
      mem_wdata = data_mem[head_q];
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)  head_q <= head_q + PtrW'(1);
      if (push) tail_q <= tail_q + PtrW'(1);
      count_q <= count_d;
      if (memwriteM && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Entry storage needs no reset: only slots covered by count_q are ever observed.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail_q] <= ALUresultM;
      data_mem[tail_q] <= writedataM;
    end
  end

  assign sb_count    = count_q;
  assign sb_empty    = (count_q == '0);
  assign sb_full     = full;
  assign sb_overflow = overflow_q;
  assign mem_raddr   = ALUresultM;

`ifdef DMEM_STORE_BUFFER_FORWARD_EN
  logic [PtrW-1:0] fwd_idx;

  // Walk valid entries oldest to youngest so the youngest match wins. The head being popped
  // this cycle is still inside count_q and therefore still forwards.
  always_comb begin
    readDataM = mem_rdata;
    fwd_idx   = head_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_idx = head_q + PtrW'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem[fwd_idx][31:2] == ALUresultM[31:2])) begin
        readDataM = data_mem[fwd_idx];
      end
    end
  end
`else
  assign readDataM = mem_rdata;
`endif

endmodule
